// File: rtl/button_event_if.sv
// Event stream interface between button_event and its consumer (GPIO/IRQ peripheral).
// Handshake: a word transfers on a clock edge where o_evt_valid & i_evt_ready; the producer
// keeps o_evt_data stable while o_evt_valid is high and not yet accepted.
interface button_event_if #(
  parameter int EW = 4
);
  logic [EW-1:0] o_evt_data;
  logic          o_evt_valid;
  logic          i_evt_ready;

  modport master (output o_evt_data, output o_evt_valid, input i_evt_ready);
  modport slave  (input o_evt_data, input o_evt_valid, output i_evt_ready);
endinterface

// File: rtl/button_event.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events queued in a small FIFO.
// Optional macro BTN_AUTOREPEAT_EN enables REPEAT events while a button stays in LONGHELD.
module button_event #(
  parameter int NUMBITS       = 3,
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int FIFO_DEPTH    = 4,
  localparam int IDXW         = (NUMBITS > 1) ? $clog2(NUMBITS) : 1,
  localparam int EW           = 2 + IDXW,
  localparam int PW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUMBITS-1:0]   i_btn,
  button_event_if.master       evt,
  output logic                 o_overflow,
  input  logic                 i_ovf_clr,
  output logic [PW-1:0]        o_pending_cnt,
  output logic [2*NUMBITS-1:0] o_dbg_state
);

  localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_TC    = CW'(REPEAT_CYCLES - 1);
  localparam logic [1:0]    EV_REPEAT = 2'b11;
`endif
  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LONGHELD = 2'd2} btn_state_t;

  logic [NUMBITS-1:0] prev_q;
  logic [NUMBITS-1:0] rise, fall;
  btn_state_t         state_q [NUMBITS];
  btn_state_t         state_d [NUMBITS];
  logic [CW-1:0]      cnt_q   [NUMBITS];
  logic [CW-1:0]      cnt_d   [NUMBITS];
  logic [NUMBITS-1:0] slot_vld_q, slot_vld_d;
  logic [1:0]         slot_typ_q [NUMBITS];
  logic [1:0]         slot_typ_d [NUMBITS];
  logic [NUMBITS-1:0] ev_hit;
  logic [1:0]         ev_typ [NUMBITS];
  logic               ovf_set;

  logic [NUMBITS-1:0] grant;
  logic               found;
  logic               push, pop, can_push;
  logic [IDXW-1:0]    push_idx;
  logic [1:0]         push_typ;

  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]      fifo_cnt_q;

  assign rise = i_btn & ~prev_q;
  assign fall = ~i_btn & prev_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop      = evt.o_evt_valid & evt.i_evt_ready;
  assign can_push = (fifo_cnt_q != PW'(FIFO_DEPTH)) | pop;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    push_idx = '0;
    push_typ = '0;
    for (int k = 0; k < NUMBITS; k++) begin
      if (slot_vld_q[k] && !found) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        push_idx = IDXW'(k);
        push_typ = slot_typ_q[k];
      end
    end
    push = found & can_push;
  end

  always_comb begin
    ovf_set    = 1'b0;
    ev_hit     = '0;
    slot_vld_d = slot_vld_q;
    for (int k = 0; k < NUMBITS; k++) begin
      state_d[k]    = state_q[k];
      cnt_d[k]      = cnt_q[k];
      slot_typ_d[k] = slot_typ_q[k];
      ev_typ[k]     = EV_PRESS;
      if (grant[k] && push) slot_vld_d[k] = 1'b0;
      case (state_q[k])
        S_IDLE: begin
          if (rise[k]) begin
            state_d[k] = S_HELD;
            cnt_d[k]   = '0;
            ev_hit[k]  = 1'b1;
            ev_typ[k]  = EV_PRESS;
          end
        end
        S_HELD: begin
          if (fall[k]) begin
            state_d[k] = S_IDLE;
            cnt_d[k]   = '0;
            ev_hit[k]  = 1'b1;
            ev_typ[k]  = EV_RELEASE;
          end else if (cnt_q[k] == LONG_TC) begin
            state_d[k] = S_LONGHELD;
            cnt_d[k]   = '0;
            ev_hit[k]  = 1'b1;
            ev_typ[k]  = EV_LONG;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
        S_LONGHELD: begin
          if (fall[k]) begin
            state_d[k] = S_IDLE;
            cnt_d[k]   = '0;
            ev_hit[k]  = 1'b1;
            ev_typ[k]  = EV_RELEASE;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (cnt_q[k] == REP_TC) begin
            cnt_d[k]  = '0;
            ev_hit[k] = 1'b1;
            ev_typ[k] = EV_REPEAT;
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
`endif
        end
        default: begin
          state_d[k] = S_IDLE;
          cnt_d[k]   = '0;
        end
      endcase
      // Newest event wins the slot; losing an unsent one is an overflow.
      if (ev_hit[k]) begin
        if (slot_vld_q[k] && !(grant[k] && push)) ovf_set = 1'b1;
        slot_vld_d[k] = 1'b1;
        slot_typ_d[k] = ev_typ[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q     <= '0;
      slot_vld_q <= '0;
      o_overflow <= 1'b0;
      for (int k = 0; k < NUMBITS; k++) begin
        state_q[k]    <= S_IDLE;
        cnt_q[k]      <= '0;
        slot_typ_q[k] <= '0;
      end
    end else begin
      prev_q     <= i_btn;
      slot_vld_q <= slot_vld_d;
      for (int k = 0; k < NUMBITS; k++) begin
        state_q[k]    <= state_d[k];
        cnt_q[k]      <= cnt_d[k];
        slot_typ_q[k] <= slot_typ_d[k];
      end
      if (ovf_set)        o_overflow <= 1'b1;
      else if (i_ovf_clr) o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {push_typ, push_idx};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      fifo_cnt_q <= fifo_cnt_q + PW'(push) - PW'(pop);
    end
  end

  assign evt.o_evt_data  = mem_q[rd_ptr_q];
  assign evt.o_evt_valid = (fifo_cnt_q != '0);
  assign o_pending_cnt   = fifo_cnt_q;

  always_comb begin
    o_dbg_state = '0;
    for (int k = 0; k < NUMBITS; k++) o_dbg_state[2*k +: 2] = state_q[k];
  end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: scoreboard of expected event words and issue cycles.
module tb_button_event;
  localparam int NB   = 3;
  localparam int LC   = 8;
  localparam int RC   = 4;
  localparam int FD   = 4;
  localparam int EW   = 4;
  localparam int PW   = 3;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [NB-1:0]   i_btn;
  logic            i_ovf_clr;
  logic            ovf;
  logic [PW-1:0]   pcnt;
  logic [2*NB-1:0] dbg;

  button_event_if #(.EW(EW)) evt_if ();

  button_event #(
    .NUMBITS(NB), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_btn         (i_btn),
    .evt           (evt_if.master),
    .o_overflow    (ovf),
    .i_ovf_clr     (i_ovf_clr),
    .o_pending_cnt (pcnt),
    .o_dbg_state   (dbg)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_t_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic expect_evt(input logic [EW-1:0] w, input int t);
    exp_q.push_back(w);
    exp_t_q.push_back(t);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    tick(4);
  endtask

  // scoreboard
  always @(negedge i_clk) begin
    if (!i_rst && evt_if.o_evt_valid && evt_if.i_evt_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_evt_qlen", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [EW-1:0] w;
        int t;
        w = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("evt_data", 32'(evt_if.o_evt_data), 32'(w));
        if (t >= 0) check("evt_cycle", cyc, t);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [NB-1:0] pat [6];
    pat = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

    i_rst = 1'b1;
    i_btn = '0;
    i_ovf_clr = 1'b0;
    evt_if.i_evt_ready = 1'b1;
    tick(3);
    check("rst_valid", 32'(evt_if.o_evt_valid), 32'd0);
    check("rst_data",  32'(evt_if.o_evt_data),  32'd0);
    check("rst_ovf",   32'(ovf),  32'd0);
    check("rst_pcnt",  32'(pcnt), 32'd0);
    i_rst = 1'b0;
    tick(2);

    // single press held 10 clocks: PRESS, LONG, RELEASE
    t = cyc;
    i_btn = 3'b010;
    expect_evt(4'h1, t + 2);
    expect_evt(4'h9, t + 10);
    tick(10);
    t = cyc;
    i_btn = 3'b000;
    expect_evt(4'h5, t + 2);
    drain(30);

    // hold button 0 for 30 clocks
    t = cyc;
    i_btn = 3'b001;
    expect_evt(4'h0, t + 2);
    expect_evt(4'h8, t + 10);
`ifdef BTN_AUTOREPEAT_EN
    for (int r = 0; r < 5; r++) expect_evt(4'hC, t + 14 + 4 * r);
`endif
    tick(30);
    t = cyc;
    i_btn = 3'b000;
    expect_evt(4'h4, t + 2);
    drain(40);

    // simultaneous press: index order on consecutive cycles
    t = cyc;
    i_btn = 3'b111;
    expect_evt(4'h0, t + 2);
    expect_evt(4'h1, t + 3);
    expect_evt(4'h2, t + 4);
    tick(4);
    i_btn = 3'b000;
    expect_evt(4'h4, t + 6);
    expect_evt(4'h5, t + 7);
    expect_evt(4'h6, t + 8);
    drain(20);
    check("multi_ovf", 32'(ovf), 32'd0);

    // back-pressure: 6 events, FIFO saturates at 4
    evt_if.i_evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_btn = pat[i];
      tick(1);
    end
    expect_evt(4'h0, -1);
    expect_evt(4'h1, -1);
    expect_evt(4'h2, -1);
    expect_evt(4'h4, -1);
    expect_evt(4'h5, -1);
    expect_evt(4'h6, -1);
    tick(3);
    check("full_pcnt",  32'(pcnt), 32'd4);
    check("full_valid", 32'(evt_if.o_evt_valid), 32'd1);
    check("full_head",  32'(evt_if.o_evt_data), 32'h0);
    check("full_ovf",   32'(ovf), 32'd0);
    i_btn = 3'b010;
    tick(1);
    i_btn = 3'b000;
    tick(1);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_pcnt", 32'(pcnt), 32'd4);
    i_ovf_clr = 1'b1;
    tick(1);
    i_ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);

    // pop from full FIFO while a slot is pending
    evt_if.i_evt_ready = 1'b1;
    tick(1);
    evt_if.i_evt_ready = 1'b0;
    check("popfull_pcnt", 32'(pcnt), 32'd4);
    check("popfull_head", 32'(evt_if.o_evt_data), 32'h1);

    // reset mid-operation with button 2 held
    i_btn = 3'b100;
    tick(2);
    i_rst = 1'b1;
    exp_q.delete();
    exp_t_q.delete();
    tick(1);
    check("mid_rst_valid", 32'(evt_if.o_evt_valid), 32'd0);
    check("mid_rst_pcnt",  32'(pcnt), 32'd0);
    check("mid_rst_ovf",   32'(ovf), 32'd0);
    i_rst = 1'b0;
    evt_if.i_evt_ready = 1'b1;
    t = cyc;
    expect_evt(4'h2, t + 2);
    tick(3);
    i_btn = 3'b000;
    expect_evt(4'h6, t + 5);
    drain(20);
    check("end_pcnt", 32'(pcnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
